// File: rtl/norm_pkg.sv
// Shared definitions for the norm_seq normalizer.
//
// Contents:
//   state_e - control FSM states (IDLE, RUN, DONE)

package norm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/norm_step.sv
// One normalization step: decides whether the working value can be shifted
// left by shift_i without losing significance, and produces the shifted value.
//
// Ports:
//   value_i - current working value
//   shift_i - step shift amount s (a power of two, s < Width)
//   next_o  - value_i << s when the shift is taken, else value_i
//   take_o  - the shift is taken
//
// Build option: NORM_SIGNED_EN
//   undefined - unsigned: shift when the top s bits are all zero
//   defined   - two's complement: shift when the top s+1 bits are all equal

module norm_step #(
    parameter int unsigned Width  = 16,
    parameter int unsigned ShiftW = $clog2(Width)
) (
    input  logic [Width-1:0]  value_i,
    input  logic [ShiftW-1:0] shift_i,
    output logic [Width-1:0]  next_o,
    output logic              take_o
);

    logic [Width-1:0] mask;

    always_comb begin
`ifdef NORM_SIGNED_EN
        // Sign bit plus the s bits that would be shifted out must all match.
        mask   = ~({Width{1'b1}} >> ({1'b0, shift_i} + {{ShiftW{1'b0}}, 1'b1}));
        take_o = ((value_i & mask) == '0) || ((value_i & mask) == mask);
`else
        mask   = ~({Width{1'b1}} >> shift_i);
        take_o = ((value_i & mask) == '0);
`endif
        next_o = take_o ? (value_i << shift_i) : value_i;
    end

endmodule

// File: rtl/norm_seq.sv
// Sequential leading-zero normalizer. Accepts a value, then performs a binary
// search over LW cycles (shift width/2, width/4, ..., 1) to left-justify it,
// reporting the total shift applied.
//
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   in_valid / in_ready  - input handshake (ready only while idle)
//   in_data              - value to normalize
//   out_valid / out_ready- result handshake (held until accepted)
//   out_data             - normalized value
//   out_count            - left-shift amount applied
//   out_zero             - accepted input was all zeros
//
// Build option: NORM_SIGNED_EN selects two's-complement normalization
// (redundant-sign-bit count) instead of unsigned leading-zero count.

module norm_seq
    import norm_pkg::*;
#(
    parameter  int unsigned width = 16,
    localparam int unsigned LW    = $clog2(width)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [width-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [width-1:0] out_data,
    output logic [LW-1:0]    out_count,
    output logic             out_zero
);

    localparam logic [LW-1:0] FirstShift = LW'(width / 2);
    localparam logic [LW-1:0] LastShift  = LW'(1);

    state_e           state_q, state_d;
    logic [width-1:0] work_q, work_d;
    logic [LW-1:0]    count_q, count_d;
    // Holds the current step's shift amount; doubles as the step counter.
    logic [LW-1:0]    shift_q, shift_d;
    logic             zero_q, zero_d;

    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [width-1:0] out_data_q, out_data_d;
    logic [LW-1:0]    out_count_q, out_count_d;
    logic             out_zero_q, out_zero_d;

    logic [width-1:0] step_next;
    logic             step_take;
    logic [LW-1:0]    count_next;

    norm_step #(
        .Width  (width),
        .ShiftW (LW)
    ) u_step (
        .value_i (work_q),
        .shift_i (shift_q),
        .next_o  (step_next),
        .take_o  (step_take)
    );

    // Shift amounts are distinct powers of two, so OR accumulates the sum.
    assign count_next = step_take ? (count_q | shift_q) : count_q;

    always_comb begin
        state_d     = state_q;
        work_d      = work_q;
        count_d     = count_q;
        shift_d     = shift_q;
        zero_d      = zero_q;
        out_data_d  = out_data_q;
        out_count_d = out_count_q;
        out_zero_d  = out_zero_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = RUN;
                    work_d  = in_data;
                    count_d = '0;
                    shift_d = FirstShift;
                    zero_d  = (in_data == '0);
                end
            end
            RUN: begin
                work_d  = step_next;
                count_d = count_next;
                if (shift_q == LastShift) begin
                    state_d     = DONE;
                    out_data_d  = step_next;
                    out_count_d = count_next;
                    out_zero_d  = zero_q;
                end else begin
                    shift_d = shift_q >> 1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            work_q      <= '0;
            count_q     <= '0;
            shift_q     <= '0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_count_q <= '0;
            out_zero_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            work_q      <= work_d;
            count_q     <= count_d;
            shift_q     <= shift_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_count_q <= out_count_d;
            out_zero_q  <= out_zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_zero  = out_zero_q;

endmodule

// File: tb/tb_norm_seq.sv
// Directed testbench for norm_seq (width=16). Expected values are hand-derived;
// the NORM_SIGNED_EN build uses the two's-complement expectations.

module tb_norm_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_data;
    logic [3:0]  out_count;
    logic        out_zero;

    int errors = 0;
    int checks = 0;

    norm_seq #(
        .width (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_zero  (out_zero)
    );

    always #5 clk = ~clk;

    // Present one input, return the ready seen before the accept edge and the
    // latency: rising edges up to out_valid, counting the accept edge as 1.
    task automatic send(input logic [15:0] d, output logic rdy, output int lat);
        @(negedge clk);
        rdy      = in_ready;
        in_valid = 1'b1;
        in_data  = d;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = 16'h0;
        lat      = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    // Complete the output handshake; ends at the negedge after the transfer.
    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 16'h0;
        out_ready = 1'b0;
        #22;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 16'h0) begin errors++; $display("FAIL reset_out_data: got %h want 0000", out_data); end
        checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
        checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL reset_out_zero: got %b want 0", out_zero); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [15:0] vin  [5];
        logic [15:0] vdat [5];
        logic [3:0]  vcnt [5];
        int          n;
        logic        rdy;
        int          lat;
`ifdef NORM_SIGNED_EN
        n = 5;
        vin[0] = 16'h0001; vdat[0] = 16'h4000; vcnt[0] = 4'd14;
        vin[1] = 16'h00F0; vdat[1] = 16'h7800; vcnt[1] = 4'd7;
        vin[2] = 16'h8001; vdat[2] = 16'h8001; vcnt[2] = 4'd0;
        vin[3] = 16'hFFF0; vdat[3] = 16'h8000; vcnt[3] = 4'd11;
        vin[4] = 16'hFFFF; vdat[4] = 16'h8000; vcnt[4] = 4'd15;
`else
        n = 3;
        vin[0] = 16'h0001; vdat[0] = 16'h8000; vcnt[0] = 4'd15;
        vin[1] = 16'h00F0; vdat[1] = 16'hF000; vcnt[1] = 4'd8;
        vin[2] = 16'h8001; vdat[2] = 16'h8001; vcnt[2] = 4'd0;
        vin[3] = 16'h0;    vdat[3] = 16'h0;    vcnt[3] = 4'd0;
        vin[4] = 16'h0;    vdat[4] = 16'h0;    vcnt[4] = 4'd0;
`endif
        for (int i = 0; i < n; i++) begin
            send(vin[i], rdy, lat);
            checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL basic_ready[%h]: got %b want 1", vin[i], rdy); end
            checks++; if (lat != 5) begin errors++; $display("FAIL basic_latency[%h]: got %0d want 5", vin[i], lat); end
            checks++; if (out_data !== vdat[i]) begin errors++; $display("FAIL basic_data[%h]: got %h want %h", vin[i], out_data, vdat[i]); end
            checks++; if (out_count !== vcnt[i]) begin errors++; $display("FAIL basic_count[%h]: got %0d want %0d", vin[i], out_count, vcnt[i]); end
            checks++; if (out_zero !== 1'b0) begin errors++; $display("FAIL basic_zero[%h]: got %b want 0", vin[i], out_zero); end
            pop();
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++; $display("FAIL basic_after_pop[%h]: got valid=%b ready=%b want valid=0 ready=1", vin[i], out_valid, in_ready);
            end
        end
    endtask

    task automatic test_zero();
        logic rdy;
        int   lat;
        send(16'h0000, rdy, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL zero_latency: got %0d want 5", lat); end
        checks++; if (out_data !== 16'h0000) begin errors++; $display("FAIL zero_data: got %h want 0000", out_data); end
        checks++; if (out_count !== 4'd15) begin errors++; $display("FAIL zero_count: got %0d want 15", out_count); end
        checks++; if (out_zero !== 1'b1) begin errors++; $display("FAIL zero_flag: got %b want 1", out_zero); end
        pop();
    endtask

    task automatic test_backpressure();
        logic        rdy;
        int          lat;
        logic [15:0] edat;
        logic [3:0]  ecnt;
`ifdef NORM_SIGNED_EN
        edat = 16'h7800; ecnt = 4'd7;
`else
        edat = 16'hF000; ecnt = 4'd8;
`endif
        send(16'h00F0, rdy, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL bp_latency: got %0d want 5", lat); end
        // A competing input while stalled must be ignored.
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int c = 0; c < 10; c++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== edat ||
                out_count !== ecnt || out_zero !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b r=%b d=%h c=%0d z=%b want v=1 r=0 d=%h c=%0d z=0",
                         c, out_valid, in_ready, out_data, out_count, out_zero, edat, ecnt);
            end
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_data  = 16'h0;
        pop();
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
                errors++;
                $display("FAIL bp_release[%0d]: got v=%b r=%b want v=0 r=1", c, out_valid, in_ready);
            end
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_run();
        logic        rdy;
        int          lat;
        logic        seen;
        logic [15:0] edat;
        logic [3:0]  ecnt;
`ifdef NORM_SIGNED_EN
        edat = 16'h4000; ecnt = 4'd6;
`else
        edat = 16'h8000; ecnt = 4'd7;
`endif
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0001;
        @(posedge clk);   // accept
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);   // step 1 done
        @(negedge clk);   // step 2 in progress
        rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
        @(negedge clk);
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_result: got out_valid=1 want 0"); end
        send(16'h0100, rdy, lat);
        checks++; if (lat != 5) begin errors++; $display("FAIL rst_next_latency: got %0d want 5", lat); end
        checks++; if (out_data !== edat) begin errors++; $display("FAIL rst_next_data: got %h want %h", out_data, edat); end
        checks++; if (out_count !== ecnt) begin errors++; $display("FAIL rst_next_count: got %0d want %0d", out_count, ecnt); end
        pop();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_zero();
        test_backpressure();
        test_reset_mid_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
